// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and per-digit compare result.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_res_t;

endpackage

// File: rtl/digit_compare.sv
// Combinational compare of one DIGIT_W-bit digit pair; the top digit can be treated as signed.
module digit_compare
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] da,
    input  logic [DIGIT_W-1:0] db,
    input  logic               is_top,
    input  logic               signed_mode,
    output cmp_res_t           res
);

    logic [DIGIT_W-1:0] msb_mask;
    logic [DIGIT_W-1:0] xa;
    logic [DIGIT_W-1:0] xb;

    // Inverting the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        msb_mask              = '0;
        msb_mask[DIGIT_W-1]   = is_top & signed_mode;
        xa                    = da ^ msb_mask;
        xb                    = db ^ msb_mask;
        res.gt                = (xa > xb);
        res.lt                = (xa < xb);
        res.eq                = (xa == xb);
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans DIGIT_W bits per clock, MSB digit first,
// stopping at the first differing digit; registered gt/lt/eq and scan-cycle count.
module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int  WIDTH   = 16,
    parameter int  DIGIT_W = 4,
    localparam int NDIG    = WIDTH / DIGIT_W,
    localparam int CNT_W   = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic [CNT_W-1:0] cycles
);

    if (DIGIT_W < 1 || DIGIT_W > WIDTH || (WIDTH % DIGIT_W) != 0) begin : g_bad_params
        $error("serial_magnitude_comparator: WIDTH must be a positive multiple of DIGIT_W");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             smode;
    logic [CNT_W-1:0] cnt;
    cmp_res_t         res;
    logic             accept;
    logic             last;
    logic             decide;

    // Operands shift left each SCAN cycle so the digit under test is always at the top.
    digit_compare #(
        .DIGIT_W (DIGIT_W)
    ) u_digit_compare (
        .da          (a_sh[WIDTH-1 -: DIGIT_W]),
        .db          (b_sh[WIDTH-1 -: DIGIT_W]),
        .is_top      (cnt == '0),
        .signed_mode (smode),
        .res         (res)
    );

    assign busy   = (state == SCAN);
    assign done   = (state == DONE);
    assign accept = start && (state != SCAN);
    assign last   = (cnt == CNT_W'(NDIG - 1));
    assign decide = (state == SCAN) && (!res.eq || last);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (decide) state_nxt = DONE;
            DONE:    state_nxt = start ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            smode  <= 1'b0;
            cnt    <= '0;
            a_gt_b <= 1'b0;
            a_lt_b <= 1'b0;
            a_eq_b <= 1'b0;
            cycles <= '0;
        end else begin
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                smode <= signed_mode;
                cnt   <= '0;
            end else if (state == SCAN) begin
                a_sh <= a_sh << DIGIT_W;
                b_sh <= b_sh << DIGIT_W;
                if (!last) cnt <= cnt + 1'b1;
            end
            if (decide) begin
                a_gt_b <= res.gt;
                a_lt_b <= res.lt;
                a_eq_b <= res.eq;
                cycles <= cnt + 1'b1;
            end
        end
    end

endmodule
